// File: rtl/lfsr_pkg.sv
// Shared types for the multi-channel LFSR pattern engine.
package lfsr_pkg;

    typedef enum logic [1:0] {
        SEED = 2'd0,
        TAP  = 2'd1,
        RUN  = 2'd2,
        MODE = 2'd3
    } cmd_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } fsm_e;

    typedef enum logic {
        FIB = 1'b0,
        GAL = 1'b1
    } mode_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step LFSR advance, Fibonacci or Galois.
// Build option LFSR_LOCKUP_EN: an all-zero result is replaced by 1 and flagged.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    input  mode_e            mode,
    output logic [WIDTH-1:0] nxt,
    output logic             zfix
);

    logic [WIDTH-1:0] w_raw;

    always_comb begin
        w_raw = '0;
        if (mode == FIB)
            w_raw = {s[WIDTH-2:0], ^(s & t)};
        else
            w_raw = (s >> 1) ^ (s[0] ? t : '0);
    end

`ifdef LFSR_LOCKUP_EN
    assign zfix = (w_raw == '0);
    assign nxt  = zfix ? WIDTH'(1) : w_raw;
`else
    assign zfix = 1'b0;
    assign nxt  = w_raw;
`endif

endmodule

// File: rtl/lfsr_bank.sv
// Multi-channel LFSR engine: per-channel seed/tap/mode, RUN streams N states out.
// Build option LFSR_LOCKUP_EN enables zero-state substitution and the lockup flags.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               CHANNELS    = 4,
    parameter int               CNT_W       = 8,
    parameter logic [WIDTH-1:0] TAP_DEFAULT = WIDTH'(16'hB400)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          cmd_valid,
    output logic                                          cmd_ready,
    input  logic [1:0]                                    cmd_op,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] cmd_ch,
    input  logic [WIDTH-1:0]                              cmd_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] out_ch,
    output logic [WIDTH-1:0]                              out_data,
    output logic                                          out_last,
    output logic                                          busy,
    output logic [CHANNELS-1:0]                           lockup
);

    localparam int CH_W = $clog2(CHANNELS > 1 ? CHANNELS : 2);

    logic [WIDTH-1:0]    r_state [CHANNELS];
    logic [WIDTH-1:0]    r_tap   [CHANNELS];
    mode_e               r_mode  [CHANNELS];
    logic [CHANNELS-1:0] r_lock;

    fsm_e                r_fsm;
    fsm_e                w_fsm_nxt;
    logic [CNT_W-1:0]    r_rem;
    logic [WIDTH-1:0]    r_out_data;
    logic [CH_W-1:0]     r_out_ch;

    cmd_op_e             w_op;
    logic                w_ch_ok;
    logic [CNT_W-1:0]    w_run_cnt;
    logic                w_cmd_fire;
    logic                w_run_start;
    logic                w_step_adv;
    logic                w_commit;
    logic [CH_W-1:0]     w_sel_ch;
    logic [WIDTH-1:0]    w_s;
    logic [WIDTH-1:0]    w_t;
    mode_e               w_mode;
    logic [WIDTH-1:0]    w_nxt;
    logic                w_zfix;

    assign w_op        = cmd_op_e'(cmd_op);
    assign w_ch_ok     = int'(cmd_ch) < CHANNELS;
    assign w_run_cnt   = CNT_W'(cmd_data);
    assign w_cmd_fire  = cmd_valid && (r_fsm == IDLE);
    assign w_run_start = w_cmd_fire && w_ch_ok && (w_op == RUN) && (w_run_cnt != '0);
    assign w_step_adv  = (r_fsm == EMIT) && out_ready && (r_rem != CNT_W'(1));
    assign w_commit    = w_run_start || w_step_adv;

    // In EMIT the current state of the running channel is exactly what is on out_data.
    assign w_sel_ch = (r_fsm == IDLE) ? cmd_ch : r_out_ch;
    assign w_s      = (r_fsm == IDLE) ? r_state[w_sel_ch] : r_out_data;
    assign w_t      = r_tap[w_sel_ch];
    assign w_mode   = r_mode[w_sel_ch];

    lfsr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .s    (w_s),
        .t    (w_t),
        .mode (w_mode),
        .nxt  (w_nxt),
        .zfix (w_zfix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= WIDTH'(1);
                r_tap[c]   <= TAP_DEFAULT;
                r_mode[c]  <= FIB;
            end
            r_lock <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_cmd_fire && w_ch_ok && int'(cmd_ch) == c) begin
                    case (w_op)
                        SEED: begin
                            r_state[c] <= cmd_data;
                            r_lock[c]  <= 1'b0;
                        end
                        TAP:     r_tap[c]  <= cmd_data;
                        MODE:    r_mode[c] <= mode_e'(cmd_data[0]);
                        default: ;
                    endcase
                end
                if (w_commit && int'(w_sel_ch) == c) begin
                    r_state[c] <= w_nxt;
                    if (w_zfix)
                        r_lock[c] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_fsm <= IDLE;
        else
            r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        case (r_fsm)
            IDLE: begin
                cmd_ready = 1'b1;
                if (w_run_start)
                    w_fsm_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (r_rem == CNT_W'(1));
                if (out_ready && r_rem == CNT_W'(1))
                    w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem      <= '0;
            r_out_data <= '0;
            r_out_ch   <= '0;
        end else begin
            if (w_run_start) begin
                r_rem    <= w_run_cnt;
                r_out_ch <= cmd_ch;
            end else if (w_step_adv) begin
                r_rem <= r_rem - CNT_W'(1);
            end
            if (w_commit)
                r_out_data <= w_nxt;
        end
    end

    assign out_data = r_out_data;
    assign out_ch   = r_out_ch;
    assign lockup   = r_lock;

endmodule
